eeprom_config_loader: RTL and testbench

//  Generalised boot-time loader for the motor board's I2C EEPROM: fetches NUM_BYTES consecutive

---
 rtl/eeprom_config_loader.sv | 183 ++++++++++++++++++
 tb/tb_eeprom_config_loader.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_config_loader.sv
// Boot-time loader for the board EEPROM: fetches NUM_BYTES bytes with per-byte timeout/retry,
// commits them atomically and rescans while ID==0. Define EEPROM_CHECKSUM_EN to read and verify a trailing checksum byte.
module eeprom_config_loader #(
    parameter int          NUM_BYTES      = 4,
    parameter logic [10:0] BASE_ADDR      = 11'h000,
    parameter int          TIMEOUT_CYCLES = 65536,
    parameter int          MAX_RETRIES    = 3,
    parameter int          RESCAN_CYCLES  = 160_000_000
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic                   reload,
    output logic [10:0]            ee_addr,
    output logic                   ee_read,
    input  logic [7:0]             ee_data,
    input  logic                   ee_ready,
    output logic [7:0]             id,
    output logic [8*NUM_BYTES-1:0] cfg_data,
    output logic                   cfg_valid,
    output logic                   busy,
    output logic                   error
);

`ifdef EEPROM_CHECKSUM_EN
    localparam int TOTAL = NUM_BYTES + 1;
`else
    localparam int TOTAL = NUM_BYTES;
`endif
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int HLD_W = $clog2(RESCAN_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(RESCAN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [TMR_W-1:0] timer;
    logic [RTY_W-1:0] retries;
    logic [HLD_W-1:0] holdoff;
    logic [7:0]       shadow [TOTAL];
    logic             restart;
    logic             sum_ok;

    function automatic logic [10:0] byte_addr(input logic [IDX_W-1:0] i);
        return BASE_ADDR + 11'(i);
    endfunction

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        restart = 1'b0;
        if (state == S_DONE)
            restart = reload || (id == 8'h00 && holdoff == HLD_LAST);
        else if (state == S_ERROR)
            restart = reload || (holdoff == HLD_LAST);
    end

`ifdef EEPROM_CHECKSUM_EN
    logic [7:0] shadow_sum;
    always_comb begin
        shadow_sum = 8'h00;
        for (int k = 0; k < TOTAL; k++)
            shadow_sum = shadow_sum + shadow[k];
    end
    assign sum_ok = (shadow_sum == 8'h00);
`else
    assign sum_ok = 1'b1;
`endif

    // NOTE: the shadow buffer has no reset; a load rewrites every entry before a commit reads it.
    always_ff @(posedge CLK) begin
        if (reset_n && state == S_WAIT && ee_ready)
            shadow[idx] <= ee_data;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state     <= S_REQ;
            idx       <= '0;
            timer     <= '0;
            retries   <= '0;
            holdoff   <= '0;
            ee_addr   <= '0;
            ee_read   <= 1'b0;
            id        <= '0;
            cfg_data  <= '0;
            cfg_valid <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            ee_read <= 1'b0;
            case (state)
                // REQ with the strobe still low is the post-reset pending request; launch it here.
                S_REQ: begin
                    if (!ee_read) begin
                        ee_addr <= byte_addr(idx);
                        ee_read <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        timer <= '0;
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (ee_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= S_CHECK;
                        end else begin
                            idx     <= idx + IDX_W'(1);
                            retries <= '0;
                            ee_addr <= byte_addr(idx + IDX_W'(1));
                            ee_read <= 1'b1;
                            state   <= S_REQ;
                        end
                    end else if (timer == TMR_LAST) begin
                        if (retries < RTY_MAX) begin
                            retries <= retries + RTY_W'(1);
                            ee_addr <= byte_addr(idx);
                            ee_read <= 1'b1;
                            state   <= S_REQ;
                        end else begin
                            error   <= 1'b1;
                            busy    <= 1'b0;
                            holdoff <= '0;
                            state   <= S_ERROR;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                // Whole shadow lands on the outputs in one edge, or not at all.
                S_CHECK: begin
                    busy    <= 1'b0;
                    holdoff <= '0;
                    if (sum_ok) begin
                        id <= shadow[0];
                        for (int k = 0; k < NUM_BYTES; k++)
                            cfg_data[8*k +: 8] <= shadow[k];
                        cfg_valid <= 1'b1;
                        error     <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        error <= 1'b1;
                        state <= S_ERROR;
                    end
                end

                S_DONE, S_ERROR: begin
                    if (restart) begin
                        idx     <= '0;
                        retries <= '0;
                        holdoff <= '0;
                        ee_addr <= BASE_ADDR;
                        ee_read <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_REQ;
                    end else if (state == S_ERROR || id == 8'h00) begin
                        holdoff <= holdoff + HLD_W'(1);
                    end else begin
                        holdoff <= '0;
                    end
                end

                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_config_loader.sv
// Randomized bench for eeprom_config_loader: a transaction-level EEPROM responder plus a
// load-outcome model. Also builds with EEPROM_CHECKSUM_EN, exercising the trailing checksum byte.
module tb_eeprom_config_loader;

    localparam int          NB     = 4;
    localparam logic [10:0] BASE   = 11'h010;
    localparam int          TMO    = 64;
    localparam int          RETRY  = 2;
    localparam int          RESCAN = 1000;
`ifdef EEPROM_CHECKSUM_EN
    localparam int TOTAL = NB + 1;
`else
    localparam int TOTAL = NB;
`endif

    logic            CLK = 1'b0;
    logic            reset_n;
    logic            reload;
    logic [10:0]     ee_addr;
    logic            ee_read;
    logic [7:0]      ee_data = 8'h00;
    logic            ee_ready = 1'b0;
    logic [7:0]      id;
    logic [8*NB-1:0] cfg_data;
    logic            cfg_valid;
    logic            busy;
    logic            error;

    eeprom_config_loader #(
        .NUM_BYTES      (NB),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES    (RETRY),
        .RESCAN_CYCLES  (RESCAN)
    ) dut (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .reload    (reload),
        .ee_addr   (ee_addr),
        .ee_read   (ee_read),
        .ee_data   (ee_data),
        .ee_ready  (ee_ready),
        .id        (id),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .busy      (busy),
        .error     (error)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // EEPROM model: byte array, per-address silence, random 1..4 cycle read latency.
    logic [7:0]  mem    [2048];
    bit          silent [2048];
    logic [10:0] strobe_addr [$];
    int unsigned strobe_cyc  [$];
    int          stray_reqs = 0;
    int          stray_seen = 0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [7:0]  pend_data = 8'h00;

    always @(negedge CLK) begin
        ee_ready = 1'b0;
        if (!reset_n) begin
            pend = 1'b0;
        end else if (pend) begin
            if (pend_cnt == 0) begin
                ee_ready = 1'b1;
                ee_data  = pend_data;
                pend     = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (stray_reqs != stray_seen) begin
            ee_ready   = 1'b1;
            ee_data    = 8'h5A;
            stray_seen = stray_reqs;
        end
        if (ee_read) begin
            strobe_addr.push_back(ee_addr);
            strobe_cyc.push_back(cyc);
            if (!silent[ee_addr]) begin
                pend      = 1'b1;
                pend_cnt  = int'($urandom_range(0, 3));
                pend_data = mem[ee_addr];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    // Committed-output model and per-load prediction.
    logic [7:0]  exp_id    = 8'h00;
    logic [31:0] exp_cfg   = 32'h0;
    bit          exp_valid = 1'b0;
    bit          exp_err   = 1'b0;
    logic [10:0] exp_q [$];
    bit          exp_ok;
    logic [31:0] new_cfg;
    int unsigned done_cyc;

    function automatic void predict();
        int sum = 0;
        exp_q.delete();
        exp_ok  = 1'b1;
        new_cfg = 32'h0;
        for (int k = 0; k < TOTAL; k++) begin
            logic [10:0] a;
            a = BASE + 11'(k);
            if (silent[a]) begin
                repeat (RETRY + 1) exp_q.push_back(a);
                exp_ok = 1'b0;
                return;
            end
            exp_q.push_back(a);
            sum += int'(mem[a]);
            if (k < NB) new_cfg = new_cfg | (32'(mem[a]) << (8 * k));
        end
        if (TOTAL > NB && (sum % 256) != 0) exp_ok = 1'b0;
    endfunction

    task automatic load_bytes(input logic [31:0] v);
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < NB; k++) begin
            mem[BASE + 11'(k)] = v[8*k +: 8];
            s = s + v[8*k +: 8];
        end
`ifdef EEPROM_CHECKSUM_EN
        mem[BASE + 11'(NB)] = 8'h00 - s;
`endif
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit seen     = 1'b0;
        bit held     = 1'b1;
        bit finished = 1'b0;
        for (int i = 0; i < budget && !finished; i++) begin
            tick();
            if (busy) begin
                seen = 1'b1;
                if (cfg_data !== exp_cfg || id !== exp_id || cfg_valid !== exp_valid) held = 1'b0;
            end else if (seen) begin
                done_cyc = cyc;
                finished = 1'b1;
            end
        end
        check({tag, "_completed"}, finished, 1);
        check({tag, "_outputs_held"}, held, 1);
    endtask

    task automatic finish_load(input string tag, input int base);
        predict();
        wait_idle(tag, 3000);
        check({tag, "_nstrobe"}, strobe_addr.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < strobe_addr.size(); i++)
            check({tag, "_addr"}, strobe_addr[base + i], exp_q[i]);
        if (exp_ok) begin
            exp_cfg   = new_cfg;
            exp_id    = new_cfg[7:0];
            exp_valid = 1'b1;
            exp_err   = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        check({tag, "_id"}, id, exp_id);
        check({tag, "_cfg"}, cfg_data, exp_cfg);
        check({tag, "_valid"}, cfg_valid, exp_valid);
        check({tag, "_error"}, error, exp_err);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_id"}, id, 0);
        check({tag, "_cfg"}, cfg_data, 0);
        check({tag, "_valid"}, cfg_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_read"}, ee_read, 0);
        check({tag, "_addr"}, ee_addr, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int unsigned rel;
        int unsigned mark;
        logic [31:0] v;

        reset_n = 1'b0;
        reload  = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            mem[i]    = 8'($urandom);
            silent[i] = 1'b0;
        end
        repeat (3) tick();
        check_reset("reset");

        // Byte at 012 never answers: three strobes 65 cycles apart, then error with nothing committed.
        load_bytes(32'h33221105);
        silent[BASE + 11'd2] = 1'b1;
        base = strobe_addr.size();
        reset_n = 1'b1;
        rel = cyc;
        finish_load("silent", base);
        check("silent_busy", busy, 0);
        if (strobe_cyc.size() > base) check("first_strobe_delay", strobe_cyc[base] - rel, 1);
        if (strobe_cyc.size() >= base + 5) begin
            check("retry_gap1", strobe_cyc[base + 3] - strobe_cyc[base + 2], TMO + 1);
            check("retry_gap2", strobe_cyc[base + 4] - strobe_cyc[base + 3], TMO + 1);
        end

        // Error holdoff expires on its own and the now-healthy EEPROM loads.
        silent[BASE + 11'd2] = 1'b0;
        mark = done_cyc;
        base = strobe_addr.size();
        finish_load("basic", base);
        if (strobe_cyc.size() > base) check("error_rescan_delay", strobe_cyc[base] - mark, RESCAN);
        check("basic_cfg_literal", cfg_data, 32'h33221105);

        // Stray ee_ready while idle must be ignored.
        base = strobe_addr.size();
        stray_reqs++;
        repeat (5) tick();
        check("stray_nstrobe", strobe_addr.size() - base, 0);
        check("stray_cfg", cfg_data, exp_cfg);
        check("stray_busy", busy, 0);

        // Reload keeps old data until the commit edge; a reload while busy is dropped.
        load_bytes(32'hCCBBAA09);
        base = strobe_addr.size();
        pulse_reload();
        repeat (3) tick();
        pulse_reload();
        finish_load("reload", base);
        repeat (4) tick();
        check("reload_not_queued", strobe_addr.size() - base, exp_q.size());
        check("reload_cfg_literal", cfg_data, 32'hCCBBAA09);

        // ID==0 rescans exactly RESCAN cycles after DONE; reload on the expiry cycle restarts once.
        load_bytes(32'h44332200);
        base = strobe_addr.size();
        pulse_reload();
        finish_load("id0", base);
        mark = done_cyc;
        base = strobe_addr.size();
        finish_load("id0_rescan", base);
        if (strobe_cyc.size() > base) check("id0_rescan_delay", strobe_cyc[base] - mark, RESCAN);
        mark = done_cyc;
        load_bytes(32'h44332207);
        base = strobe_addr.size();
        for (int i = 0; i < 2 * RESCAN && cyc < mark + RESCAN - 1; i++) tick();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        finish_load("collide", base);
        if (strobe_cyc.size() > base) check("collide_delay", strobe_cyc[base] - mark, RESCAN);
        check("collide_id_literal", id, 8'h07);

`ifdef EEPROM_CHECKSUM_EN
        // Bad checksum leaves outputs alone; fixing the trailing byte commits.
        mem[BASE]       = 8'h05;
        mem[BASE + 11'd1] = 8'h11;
        mem[BASE + 11'd2] = 8'h22;
        mem[BASE + 11'd3] = 8'h33;
        mem[BASE + 11'd4] = 8'h00;
        base = strobe_addr.size();
        pulse_reload();
        finish_load("csum_bad", base);
        check("csum_bad_error", error, 1);
        mem[BASE + 11'd4] = 8'h95;
        base = strobe_addr.size();
        pulse_reload();
        finish_load("csum_good", base);
        check("csum_good_error", error, 0);
        check("csum_good_cfg", cfg_data, 32'h33221105);
`endif

        // Random contents, occasional silent byte or corrupted checksum.
        for (int it = 0; it < 10; it++) begin
            v = $urandom;
            if (v[7:0] == 8'h00) v[7:0] = 8'h01;
            load_bytes(v);
            if ($urandom_range(0, 3) == 0) silent[BASE + 11'($urandom_range(0, TOTAL - 1))] = 1'b1;
`ifdef EEPROM_CHECKSUM_EN
            if ($urandom_range(0, 3) == 0) mem[BASE + 11'(NB)] = mem[BASE + 11'(NB)] ^ 8'h01;
`endif
            base = strobe_addr.size();
            pulse_reload();
            finish_load("random", base);
            for (int k = 0; k < TOTAL; k++) silent[BASE + 11'(k)] = 1'b0;
        end

        // Reset during the wait for byte 011 aborts everything; load restarts at 010.
        load_bytes(32'h33221105);
        silent[BASE + 11'd1] = 1'b1;
        base = strobe_addr.size();
        pulse_reload();
        for (int i = 0; i < 200 && strobe_addr.size() < base + 2; i++) tick();
        check("mid_reset_reached", strobe_addr.size() >= base + 2, 1);
        tick();
        reset_n = 1'b0;
        tick();
        check_reset("mid_reset");
        exp_id    = 8'h00;
        exp_cfg   = 32'h0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        silent[BASE + 11'd1] = 1'b0;
        repeat (2) tick();
        base = strobe_addr.size();
        reset_n = 1'b1;
        rel = cyc;
        finish_load("after_reset", base);
        if (strobe_cyc.size() > base) check("after_reset_delay", strobe_cyc[base] - rel, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
